// File: rtl/player_id_enroll_pkg.sv
// rtl/player_id_enroll_pkg.sv - shared constants and state encoding for the player-ID RAM blocks
package player_id_enroll_pkg;

    localparam logic [15:0] TERM          = 16'hFFFF;
    localparam logic [15:0] GUEST_ID      = 16'h5973;
    localparam int          RD_LAT_DEF    = 3;
    localparam int          MAX_SLOTS_DEF = 8;
    localparam int          ADDR_W        = 5;
    localparam int          ID_W          = 16;

    // Encoding is shared with the ID checker so both can be decoded the same way on a probe bus.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_D1       = 4'd1,
        ST_D2       = 4'd2,
        ST_D3       = 4'd3,
        ST_D4       = 4'd4,
        ST_CHK      = 4'd5,
        ST_FETCH    = 4'd6,
        ST_WAIT     = 4'd7,
        ST_CATCH    = 4'd8,
        ST_CMP      = 4'd9,
        ST_WR_TERM  = 4'd10,
        ST_WR_ID    = 4'd11,
        ST_DONE     = 4'd12
    } enroll_state_e;

endpackage

// File: rtl/player_id_enroll_if.sv
// rtl/player_id_enroll_if.sv - player-ID RAM port bundle
interface player_id_enroll_if;
    import player_id_enroll_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic [ID_W-1:0]   data_wr;
    logic              wren;
    logic [ID_W-1:0]   data_ram_ID;

    modport master (
        output addr,
        output data_wr,
        output wren,
        input  data_ram_ID
    );

    modport slave (
        input  addr,
        input  data_wr,
        input  wren,
        output data_ram_ID
    );

endinterface

// File: rtl/player_id_enroll.sv
// rtl/player_id_enroll.sv - enrols 4-digit player IDs into the player-ID RAM
module player_id_enroll
    import player_id_enroll_pkg::*;
#(
    parameter int          RD_LAT    = RD_LAT_DEF,
    parameter int          MAX_SLOTS = MAX_SLOTS_DEF,
    parameter logic [15:0] TERM_VAL  = TERM
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enroll_en,
    input  logic                   UserLoad,
    input  logic [3:0]             UserDigit,
    player_id_enroll_if.master     ram,
    output logic                   enrolled,
    output logic                   dup_err,
    output logic                   full_err,
    output logic                   bad_err,
    output logic [2:0]             new_PlayerID
);

    localparam int                CNT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(MAX_SLOTS - 1);
    localparam logic [CNT_W-1:0]  CNT_TOP = CNT_W'(RD_LAT - 1);

    enroll_state_e     state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        slot_q, slot_d;
    logic [ID_W-1:0]   data_wr_q, data_wr_d;
    logic              wren_q, wren_d;
    logic              enrolled_q, enrolled_d;
    logic              dup_q, dup_d;
    logic              full_q, full_d;
    logic              bad_q, bad_d;
    logic [2:0]        new_id_q, new_id_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            id_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            slot_q     <= '0;
            data_wr_q  <= '0;
            wren_q     <= 1'b0;
            enrolled_q <= 1'b0;
            dup_q      <= 1'b0;
            full_q     <= 1'b0;
            bad_q      <= 1'b0;
            new_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            slot_q     <= slot_d;
            data_wr_q  <= data_wr_d;
            wren_q     <= wren_d;
            enrolled_q <= enrolled_d;
            dup_q      <= dup_d;
            full_q     <= full_d;
            bad_q      <= bad_d;
            new_id_q   <= new_id_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        slot_d     = slot_q;
        data_wr_d  = data_wr_q;
        wren_d     = 1'b0;
        enrolled_d = enrolled_q;
        dup_d      = dup_q;
        full_d     = full_q;
        bad_d      = bad_q;
        new_id_d   = new_id_q;

        case (state_q)
            ST_IDLE: begin
                enrolled_d = 1'b0;
                dup_d      = 1'b0;
                full_d     = 1'b0;
                bad_d      = 1'b0;
                new_id_d   = '0;
                if (enroll_en) state_d = ST_D1;
            end
            ST_D1: if (UserLoad) begin id_d[15:12] = UserDigit; state_d = ST_D2; end
            ST_D2: if (UserLoad) begin id_d[11:8]  = UserDigit; state_d = ST_D3; end
            ST_D3: if (UserLoad) begin id_d[7:4]   = UserDigit; state_d = ST_D4; end
            ST_D4: if (UserLoad) begin id_d[3:0]   = UserDigit; state_d = ST_CHK; end
            ST_CHK: begin
                if (id_q == TERM_VAL) begin
                    bad_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    addr_d  = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                cnt_d   = CNT_TOP;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_CATCH;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_CATCH: begin
                rd_d    = ram.data_ram_ID;
                state_d = ST_CMP;
            end
            ST_CMP: begin
                // Last-slot test precedes any increment, so addr never wraps past the table.
                if (rd_q == id_q) begin
                    dup_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (rd_q == TERM_VAL) begin
                    if (addr_q == LAST) begin
                        full_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        slot_d    = addr_q[2:0];
                        addr_d    = addr_q + ADDR_W'(1);
                        data_wr_d = TERM_VAL;
                        wren_d    = 1'b1;
                        state_d   = ST_WR_TERM;
                    end
                end else if (addr_q == LAST) begin
                    full_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = ST_FETCH;
                end
            end
            ST_WR_TERM: begin
                // New terminator lands before the ID overwrites the old one.
                addr_d    = {2'b00, slot_q};
                data_wr_d = id_q;
                wren_d    = 1'b1;
                state_d   = ST_WR_ID;
            end
            ST_WR_ID: begin
                enrolled_d = 1'b1;
                new_id_d   = slot_q;
                state_d    = ST_DONE;
            end
            ST_DONE: ;
            default: state_d = ST_IDLE;
        endcase

        if (!enroll_en && state_q != ST_WR_TERM && state_q != ST_WR_ID) begin
            state_d    = ST_IDLE;
            wren_d     = 1'b0;
            enrolled_d = 1'b0;
            dup_d      = 1'b0;
            full_d     = 1'b0;
            bad_d      = 1'b0;
            new_id_d   = '0;
        end
    end

    assign ram.addr     = addr_q;
    assign ram.data_wr  = data_wr_q;
    assign ram.wren     = wren_q;
    assign enrolled     = enrolled_q;
    assign dup_err      = dup_q;
    assign full_err     = full_q;
    assign bad_err      = bad_q;
    assign new_PlayerID = new_id_q;

endmodule

// File: tb/tb_player_id_enroll.sv
// tb/tb_player_id_enroll.sv - scoreboard bench for player_id_enroll
module tb_player_id_enroll;
    import player_id_enroll_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enroll_en = 1'b0;
    logic       UserLoad = 1'b0;
    logic [3:0] UserDigit = 4'h0;
    logic       enrolled, dup_err, full_err, bad_err;
    logic [2:0] new_PlayerID;

    player_id_enroll_if ram_if();

    player_id_enroll dut (
        .clk          (clk),
        .rst          (rst),
        .enroll_en    (enroll_en),
        .UserLoad     (UserLoad),
        .UserDigit    (UserDigit),
        .ram          (ram_if),
        .enrolled     (enrolled),
        .dup_err      (dup_err),
        .full_err     (full_err),
        .bad_err      (bad_err),
        .new_PlayerID (new_PlayerID)
    );

    always #5 clk = ~clk;

    logic [15:0] mem      [0:31];
    logic [15:0] load_img [0:31];
    logic        load_req = 1'b0;
    logic [15:0] p1 = '0, p2 = '0, p3 = '0;

    always @(posedge clk) begin
        if (load_req)         mem <= load_img;
        else if (ram_if.wren) mem[ram_if.addr] <= ram_if.data_wr;
        p1 <= mem[ram_if.addr];
        p2 <= p1;
        p3 <= p2;
    end
    assign ram_if.data_ram_ID = p3;

    typedef struct packed { logic [4:0] addr; logic [15:0] data; } wr_t;
    typedef struct packed { logic e; logic d; logic f; logic b; logic [2:0] pid; } res_t;

    wr_t  wr_q [$];
    res_t res_q[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_flag = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int find_id(input logic [15:0] id);
        for (int i = 0; i < 8; i++) begin
            if (mem[i] == TERM) return -1;
            if (mem[i] == id)   return i;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        logic any;
        if (ram_if.wren) begin
            if (wr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_wren: got addr %h data %h expected no write", ram_if.addr, ram_if.data_wr);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                check("wr_addr", 32'(ram_if.addr), 32'(e.addr));
                check("wr_data", 32'(ram_if.data_wr), 32'(e.data));
            end
        end
        any = enrolled | dup_err | full_err | bad_err;
        if (any && !prev_flag) begin
            if (res_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_result: got flags %b%b%b%b expected none", enrolled, dup_err, full_err, bad_err);
            end else begin
                res_t r;
                r = res_q.pop_front();
                check("result", 32'({enrolled, dup_err, full_err, bad_err, new_PlayerID}), 32'(r));
            end
        end
        prev_flag = any;
    end

    task automatic set_table(input int mode);
        @(negedge clk);
        for (int i = 0; i < 32; i++) load_img[i] = 16'h0000;
        case (mode)
            0: begin load_img[0] = 16'h1234; load_img[1] = 16'h5973; load_img[2] = TERM; end
            1: begin for (int i = 0; i < 7; i++) load_img[i] = 16'h1000 + 16'(i); load_img[7] = TERM; end
            default: for (int i = 0; i < 8; i++) load_img[i] = 16'h3000 + 16'(i);
        endcase
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic load_digits(input logic [15:0] id);
        @(negedge clk);
        enroll_en = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            UserDigit = id[15-4*d -: 4];
            UserLoad  = 1'b1;
            @(negedge clk);
            UserLoad  = 1'b0;
            if (d < 3) @(negedge clk);
        end
    endtask

    task automatic enter_id(input logic [15:0] id, output int lat);
        load_digits(id);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(enrolled | dup_err | full_err | bad_err) && lat < 200);
        if (lat >= 200) begin
            checks++; errors++;
            $display("FAIL timeout_done: got no flag after %0d cycles expected a flag", lat);
        end
    endtask

    task automatic finish_done();
        enroll_en = 1'b0;
        @(negedge clk);
        check("flags_clear", 32'({enrolled, dup_err, full_err, bad_err, new_PlayerID}), 32'h0);
    endtask

    initial begin
        int lat;
        int n;

        repeat (2) @(negedge clk);
        check("reset_out", 32'({ram_if.addr, ram_if.data_wr, ram_if.wren, enrolled, dup_err,
                                full_err, bad_err, new_PlayerID}), 32'h0);
        rst = 1'b1;

        // Successful enrolment at terminator slot 2.
        set_table(0);
        wr_q.push_back('{addr: 5'd3, data: 16'hFFFF});
        wr_q.push_back('{addr: 5'd2, data: 16'h4821});
        res_q.push_back('{e: 1'b1, d: 1'b0, f: 1'b0, b: 1'b0, pid: 3'd2});
        enter_id(16'h4821, lat);
        check("lat_enroll", 32'(lat), 32'd21);
        finish_done();
        check("checker_4821", 32'(find_id(16'h4821)), 32'd2);
        check("new_term", 32'(mem[3]), 32'hFFFF);

        // Duplicates, including the reserved guest ID.
        res_q.push_back('{e: 1'b0, d: 1'b1, f: 1'b0, b: 1'b0, pid: 3'd0});
        enter_id(16'h1234, lat);
        check("lat_dup", 32'(lat), 32'd7);
        finish_done();
        res_q.push_back('{e: 1'b0, d: 1'b1, f: 1'b0, b: 1'b0, pid: 3'd0});
        enter_id(GUEST_ID, lat);
        finish_done();

        // Full table, with and without a terminator in the last slot.
        set_table(1);
        res_q.push_back('{e: 1'b0, d: 1'b0, f: 1'b1, b: 1'b0, pid: 3'd0});
        enter_id(16'h2468, lat);
        finish_done();
        check("full_last_term", 32'(mem[7]), 32'hFFFF);
        set_table(2);
        res_q.push_back('{e: 1'b0, d: 1'b0, f: 1'b1, b: 1'b0, pid: 3'd0});
        enter_id(16'h2468, lat);
        finish_done();

        // Terminator value entered as an ID.
        set_table(0);
        res_q.push_back('{e: 1'b0, d: 1'b0, f: 1'b0, b: 1'b1, pid: 3'd0});
        enter_id(16'hFFFF, lat);
        check("lat_bad", 32'(lat), 32'd1);
        finish_done();

        // Abort after two digits, then a fresh entry must start from the first digit.
        @(negedge clk);
        enroll_en = 1'b1;
        @(negedge clk);
        UserDigit = 4'h1; UserLoad = 1'b1;
        @(negedge clk);
        UserLoad = 1'b0;
        @(negedge clk);
        UserDigit = 4'h2; UserLoad = 1'b1;
        @(negedge clk);
        UserLoad = 1'b0;
        enroll_en = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_flags", 32'({enrolled, dup_err, full_err, bad_err}), 32'h0);
        res_q.push_back('{e: 1'b0, d: 1'b1, f: 1'b0, b: 1'b0, pid: 3'd0});
        enter_id(16'h1234, lat);
        finish_done();

        // Asynchronous reset while waiting on a RAM read.
        load_digits(16'h2468);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        enroll_en = 1'b0;
        #1 check("async_rst_out", 32'({ram_if.addr, ram_if.data_wr, ram_if.wren, enrolled, dup_err,
                                       full_err, bad_err, new_PlayerID}), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        check("table_kept", 32'({mem[1], mem[2]}), 32'h5973FFFF);

        // Reset between the terminator write and the ID write.
        wr_q.push_back('{addr: 5'd3, data: 16'hFFFF});
        load_digits(16'h4821);
        n = 0;
        while (!ram_if.wren && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wr_term_seen", 32'(ram_if.wren), 32'h1);
        @(posedge clk);
        #2 rst = 1'b0;
        enroll_en = 1'b0;
        #1 check("rst_wren", 32'(ram_if.wren), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("chk_1234", 32'(find_id(16'h1234)), 32'd0);
        check("chk_5973", 32'(find_id(16'h5973)), 32'd1);
        check("dup_term", 32'({mem[2], mem[3]}), 32'hFFFFFFFF);

        check("wr_queue_empty", 32'(wr_q.size()), 32'd0);
        check("res_queue_empty", 32'(res_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
